// File: rtl/mouse_pos_tracker_pkg.sv
// Shared definitions for the PS/2 mouse position tracker.
//   state_t    : packet assembly states
//   hdr_t      : the byte0 fields that survive past the capture cycle
//   bit indices: positions of the flags inside PS/2 byte0
//   XMAX_DEF / YMAX_DEF : default screen limits
package mouse_pos_tracker_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  localparam int XMAX_DEF = 799;
  localparam int YMAX_DEF = 599;

  typedef struct packed {
    logic yovf;
    logic xovf;
    logic ysign;
    logic xsign;
    logic btn_r;
    logic btn_l;
  } hdr_t;

  // Build the 14-bit signed delta from a sign bit and a low byte; an
  // overflowed axis contributes no motion.
  function automatic logic signed [13:0] make_delta(input logic sign,
                                                    input logic ovf,
                                                    input logic [7:0] low);
    if (ovf)
      return 14'sd0;
    return $signed({{5{sign}}, sign, low});
  endfunction

endpackage

// File: rtl/mouse_pos_tracker_clamp.sv
// pos_clamp_acc: adds a signed 14-bit delta to an unsigned 12-bit position
// and saturates the result into 0..MAX.
//   pos    : current position (0..MAX)
//   delta  : signed step
//   result : clamped new position
module pos_clamp_acc #(
  parameter int MAX = 799
) (
  input  logic               [11:0] pos,
  input  logic signed        [13:0] delta,
  output logic               [11:0] result
);

  localparam logic signed [13:0] MAX_S = 14'(MAX);

  logic signed [13:0] sum;

  // 14 bits hold pos (<4096) plus any 9-bit delta without overflow.
  assign sum = $signed({2'b00, pos}) + delta;

  always_comb begin
    if (sum < 14'sd0)
      result = 12'd0;
    else if (sum > MAX_S)
      result = MAX_S[11:0];
    else
      result = sum[11:0];
  end

endmodule

// File: rtl/mouse_pos_tracker.sv
// mouse_pos_tracker: assembles 3-byte PS/2 mouse packets and keeps a
// clamped absolute cursor position plus button state.
//   clk_in      : system clock
//   rst         : asynchronous active-high reset
//   rx_data     : received PS/2 byte
//   rx_valid    : one-cycle strobe qualifying rx_data
//   mouse_xpos  : absolute x, 0..XMAX
//   mouse_ypos  : absolute y, 0..YMAX, down is positive
//   mouse_left  : left button from last good packet
//   mouse_right : right button from last good packet
//   pkt_valid   : one-cycle pulse when outputs update
//   sync_err    : one-cycle pulse when a byte/partial packet is dropped
module mouse_pos_tracker
  import mouse_pos_tracker_pkg::*;
#(
  parameter int XMAX    = XMAX_DEF,
  parameter int YMAX    = YMAX_DEF,
  parameter int X_INIT  = 400,
  parameter int Y_INIT  = 300,
  parameter int TIMEOUT = 80000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [11:0] mouse_xpos,
  output logic [11:0] mouse_ypos,
  output logic        mouse_left,
  output logic        mouse_right,
  output logic        pkt_valid,
  output logic        sync_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state, state_next;
  hdr_t           hdr;
  logic [7:0]     byte1, byte2;
  logic [CW-1:0]  idle_cnt;
  logic           sync_pend;

  // Control strobes decoded from state and input.
  logic take_b0, take_b1, take_b2, drop_byte, timeout_hit, load_pos;

  logic signed [13:0] dx, dy, step_y;
  logic        [11:0] nx, ny;

  // Bit 2 of byte0 carries no information for this design.
  logic unused_bit2;
  assign unused_bit2 = rx_data[2];

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      state <= WAIT_B0;
    else
      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_B0: if (take_b0) state_next = WAIT_B1;
      WAIT_B1: begin
        if (take_b1)          state_next = WAIT_B2;
        else if (timeout_hit) state_next = WAIT_B0;
      end
      WAIT_B2: begin
        if (take_b2)          state_next = UPDATE;
        else if (timeout_hit) state_next = WAIT_B0;
      end
      UPDATE:  state_next = take_b0 ? WAIT_B1 : WAIT_B0;
      default: state_next = WAIT_B0;
    endcase
  end

  // Output/strobe decode. UPDATE accepts a header byte exactly like
  // WAIT_B0 so back-to-back packets lose nothing.
  always_comb begin
    take_b0     = 1'b0;
    take_b1     = 1'b0;
    take_b2     = 1'b0;
    drop_byte   = 1'b0;
    timeout_hit = 1'b0;
    load_pos    = 1'b0;
    case (state)
      WAIT_B0, UPDATE: begin
        if (rx_valid) begin
          if (rx_data[ALWAYS1]) take_b0   = 1'b1;
          else                  drop_byte = 1'b1;
        end
        load_pos = (state == UPDATE);
      end
      WAIT_B1: begin
        if (rx_valid)                           take_b1     = 1'b1;
        else if (idle_cnt == CW'(TIMEOUT - 1))  timeout_hit = 1'b1;
      end
      WAIT_B2: begin
        if (rx_valid)                           take_b2     = 1'b1;
        else if (idle_cnt == CW'(TIMEOUT - 1))  timeout_hit = 1'b1;
      end
      default: ;
    endcase
  end

  // Packet capture and idle counter.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hdr      <= '0;
      byte1    <= '0;
      byte2    <= '0;
      idle_cnt <= '0;
    end else begin
      if (take_b0) begin
        hdr.btn_l <= rx_data[BTN_L];
        hdr.btn_r <= rx_data[BTN_R];
        hdr.xsign <= rx_data[XSIGN];
        hdr.ysign <= rx_data[YSIGN];
        hdr.xovf  <= rx_data[XOVF];
        hdr.yovf  <= rx_data[YOVF];
      end
      if (take_b1) byte1 <= rx_data;
      if (take_b2) byte2 <= rx_data;
      if ((state == WAIT_B1 || state == WAIT_B2) && !rx_valid && !timeout_hit)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;
    end
  end

  assign dx     = make_delta(hdr.xsign, hdr.xovf, byte1);
  assign dy     = make_delta(hdr.ysign, hdr.yovf, byte2);
  assign step_y = -dy;  // PS/2 y is up-positive, screen y is down-positive

  pos_clamp_acc #(.MAX(XMAX)) u_clamp_x (
    .pos    (mouse_xpos),
    .delta  (dx),
    .result (nx)
  );

  pos_clamp_acc #(.MAX(YMAX)) u_clamp_y (
    .pos    (mouse_ypos),
    .delta  (step_y),
    .result (ny)
  );

  // Registered outputs. A bad byte seen during UPDATE would collide with
  // the pkt_valid pulse, so its sync_err is deferred by one cycle.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mouse_xpos  <= 12'(X_INIT);
      mouse_ypos  <= 12'(Y_INIT);
      mouse_left  <= 1'b0;
      mouse_right <= 1'b0;
      pkt_valid   <= 1'b0;
      sync_err    <= 1'b0;
      sync_pend   <= 1'b0;
    end else begin
      pkt_valid <= load_pos;
      sync_pend <= load_pos && drop_byte;
      sync_err  <= sync_pend || timeout_hit || (drop_byte && !load_pos);
      if (load_pos) begin
        mouse_xpos  <= nx;
        mouse_ypos  <= ny;
        mouse_left  <= hdr.btn_l;
        mouse_right <= hdr.btn_r;
      end
    end
  end

endmodule
